// File: rtl/fp_mac_acc_engine.sv
// fp_mac_acc_engine: Avalon-MM binary32 multiply-accumulate engine (flush-to-zero, round toward zero).
// Optional sticky exception flags register is built when FP_MAC_ACC_FLAGS_EN is defined.
module fp_mac_acc_engine #(
  parameter int unsigned LEN_W    = 8,
  parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  output logic [31:0] readdata
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, ADD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [31:0]      opa_q, opb_q, acc_q, prod_q;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_nxt;
  logic             done_q, mode_q;
  logic             busy, access, wr_acc, rd_acc, clear_cmd;

  // Product: result in [31:0], {underflow, overflow, invalid} in [34:32]
  function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [24:0] ph;
    logic [9:0]  ex;
    logic [34:0] r;
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    ph     = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
    ex     = {2'b00, a[30:23]} + {2'b00, b[30:23]} + 10'(ph[24]);
    r      = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = {3'b001, QNAN};
    else if (a_inf || b_inf)   r = {3'b000, sgn, 8'hFF, 23'd0};
    else if (a_zero || b_zero) r = {3'b000, sgn, 31'd0};
    else if (ex >= 10'd382)    r = {3'b010, sgn, 8'hFF, 23'd0};
    else if (ex <= 10'd127)    r = {3'b100, sgn, 31'd0};
    else r = {3'b000, sgn, 8'(ex - 10'd127), (ph[24] ? ph[23:1] : ph[22:0])};
    return r;
  endfunction

  // Sum: same packing as fp_mul; guard/round/sticky keep truncation exact
  function automatic logic [34:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, eff_sub;
    logic [31:0] big, sml;
    logic [7:0]  d;
    logic [26:0] mb, ms, sh;
    logic [27:0] sum;
    logic [4:0]  p;
    logic [9:0]  ex;
    logic [34:0] r;
    a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero  = (a[30:23] == 8'h00);
    b_zero  = (b[30:23] == 8'h00);
    swap    = (b[30:0] > a[30:0]);
    big     = swap ? b : a;
    sml     = swap ? a : b;
    d       = big[30:23] - sml[30:23];
    eff_sub = big[31] ^ sml[31];
    mb      = {1'b1, big[22:0], 3'b000};
    ms      = {1'b1, sml[22:0], 3'b000};
    if (d >= 8'd27) begin
      sh = 27'd1;
    end else begin
      sh = ms >> d;
      if ((ms & ~({27{1'b1}} << d)) != 27'd0) sh[0] = 1'b1;
    end
    sum = eff_sub ? ({1'b0, mb} - {1'b0, sh}) : ({1'b0, mb} + {1'b0, sh});
    p   = 5'd0;
    for (int i = 0; i < 28; i++) if (sum[i]) p = 5'(i);
    ex  = {2'b00, big[30:23]} + 10'(p);
    r   = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) r = {3'b001, QNAN};
    else if (a_inf)              r = {3'b000, a};
    else if (b_inf)              r = {3'b000, b};
    else if (a_zero && b_zero)   r = {3'b000, a[31] & b[31], 31'd0};
    else if (a_zero)             r = {3'b000, b};
    else if (b_zero)             r = {3'b000, a};
    else if (sum == 28'd0)       r = '0;
    else if (ex >= 10'd281)      r = {3'b010, big[31], 8'hFF, 23'd0};
    else if (ex <= 10'd26)       r = {3'b100, big[31], 31'd0};
    else r = {3'b000, big[31], 8'(ex - 10'd26), 23'((sum << (5'd27 - p)) >> 4)};
    return r;
  endfunction

`ifdef FP_MAC_ACC_FLAGS_EN
  logic [34:0] mul_w, add_w;
  assign mul_w = fp_mul(opa_q, opb_q);
  assign add_w = fp_add(acc_q, prod_q);
`else
  logic [31:0] mul_w, add_w;
  assign mul_w = 32'(fp_mul(opa_q, opb_q));
  assign add_w = 32'(fp_add(acc_q, prod_q));
`endif

  assign busy      = (state_q != IDLE);
  assign access    = chipselect & (read | write);
  assign wr_acc    = chipselect & write & ~busy;
  assign rd_acc    = chipselect & read & ~busy;
  assign clear_cmd = wr_acc && (address == 3'd3) && writedata[0];
  assign cnt_nxt   = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and stall generation
  always_comb begin
    state_d     = state_q;
    waitrequest = access && (state_q != IDLE);
    case (state_q)
      IDLE:    if (wr_acc && (address == 3'd1)) state_d = MUL;
      MUL:     state_d = ADD;
      ADD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Host register writes and the MUL/ADD pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q  <= '0;
      opb_q  <= '0;
      prod_q <= '0;
      acc_q  <= ACC_INIT;
      len_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      if (state_q == MUL) prod_q <= mul_w[31:0];
      if (state_q == ADD) begin
        acc_q <= mode_q ? prod_q : add_w[31:0];
        cnt_q <= cnt_nxt;
        if ((len_q != '0) && (cnt_nxt == len_q)) done_q <= 1'b1;
      end
      if (wr_acc) begin
        case (address)
          3'd0: opa_q <= writedata;
          3'd1: opb_q <= writedata;
          3'd2: acc_q <= writedata;
          3'd3: begin
            mode_q <= writedata[1];
            if (writedata[0]) begin
              acc_q  <= ACC_INIT;
              cnt_q  <= '0;
              done_q <= 1'b0;
            end
          end
          3'd4: begin
            len_q  <= writedata[LEN_W-1:0];
            done_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FP_MAC_ACC_FLAGS_EN
  logic [2:0] flags_q, pflags_q;

  // Sticky exception flags; cleared by reading them or by a clear command
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= '0;
      pflags_q <= '0;
    end else begin
      if (state_q == MUL) pflags_q <= mul_w[34:32];
      if (clear_cmd || (rd_acc && (address == 3'd5))) flags_q <= '0;
      else if (state_q == ADD) flags_q <= flags_q | pflags_q | (mode_q ? 3'b000 : add_w[34:32]);
    end
  end
`endif

  // Read mux, zero whenever no read is being accepted
  always_comb begin
    readdata = 32'd0;
    if (rd_acc) begin
      case (address)
        3'd2:    readdata = acc_q;
        3'd3:    readdata = 32'({cnt_q, done_q, busy});
        3'd4:    readdata = 32'(len_q);
`ifdef FP_MAC_ACC_FLAGS_EN
        3'd5:    readdata = 32'(flags_q);
`endif
        default: readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mac_acc_engine.sv
// tb_fp_mac_acc_engine: scoreboard bench for the binary32 MAC engine.
module tb_fp_mac_acc_engine;

`ifdef FP_MAC_ACC_FLAGS_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  fp_mac_acc_engine #(.LEN_W(8), .ACC_INIT(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .writedata(writedata), .write(write), .read(read),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Bus write starting at a negedge; returns number of stalled edges
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    #1;
    while (waitrequest && stalls < 16) begin
      @(negedge clk); #1; stalls++;
    end
    if (waitrequest) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout: addr %0d still stalled after %0d cycles, required accept", a, stalls);
    end
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0;
  endtask

  // Bus read starting at a negedge; data sampled just before the accepting edge
  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int stalls);
    stalls = 0;
    chipselect = 1'b1; read = 1'b1; address = a;
    #1;
    while (waitrequest && stalls < 16) begin
      @(negedge clk); #1; stalls++;
    end
    if (waitrequest) begin
      n_cmp++; n_err++;
      $display("FAIL read_timeout: addr %0d still stalled after %0d cycles, required accept", a, stalls);
    end
    d = readdata;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; address = 3'd0;
  endtask

  // Issue one operation and record its expected accumulator value
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int st;
    bus_write(3'd0, a, st);
    bus_write(3'd1, b, st);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [31:0] got;
    int st;
    chipselect = 1'b1; #1;
    n_cmp++;
    if (waitrequest !== 1'b0 || readdata !== 32'd0) begin
      n_err++; $display("FAIL reset_idle_outputs: got wr=%b rd=%h, required 0/0", waitrequest, readdata);
    end
    chipselect = 1'b0;
    @(negedge clk);
    for (int i = 2; i < 8; i++) begin
      bus_read(3'(i), got, st);
      n_cmp++;
      if (got !== 32'd0) begin
        n_err++; $display("FAIL reset_reg%0d: got %h, required 00000000", i, got);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] got, e;
    int st;
    do_op(32'h3FC00000, 32'h40000000, 32'h40400000);
    bus_read(3'd2, got, st);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL basic_acc: got %h, required %h", got, e); end
    n_cmp++;
    if (st != 2) begin n_err++; $display("FAIL basic_latency: got %0d stalls, required 2", st); end
    bus_read(3'd3, got, st);
    n_cmp++;
    if (got !== 32'h4) begin n_err++; $display("FAIL basic_status: got %h, required 00000004", got); end
  endtask

  task automatic test_len_done();
    logic [31:0] av[4], bv[4], sv[4];
    logic [31:0] got, e;
    int st;
    av = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h3F800000};
    bv = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h3F800000};
    sv = '{32'h4, 32'h8, 32'hE, 32'h12};
    bus_write(3'd4, 32'd3, st);
    bus_write(3'd3, 32'h1, st);
    exp_q.push_back(32'h40000000);
    exp_q.push_back(32'h41600000);
    exp_q.push_back(32'h42300000);
    exp_q.push_back(32'h42340000);
    for (int i = 0; i < 4; i++) begin
      bus_write(3'd0, av[i], st);
      bus_write(3'd1, bv[i], st);
      bus_read(3'd2, got, st);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL dot_acc%0d: got %h, required %h", i, got, e); end
      bus_read(3'd3, got, st);
      n_cmp++;
      if (got !== sv[i]) begin n_err++; $display("FAIL dot_status%0d: got %h, required %h", i, got, sv[i]); end
    end
    bus_write(3'd2, 32'h3F800000, st);
    bus_read(3'd3, got, st);
    n_cmp++;
    if (got !== 32'h12) begin n_err++; $display("FAIL accwr_status: got %h, required 00000012", got); end
    bus_read(3'd2, got, st);
    n_cmp++;
    if (got !== 32'h3F800000) begin n_err++; $display("FAIL accwr_value: got %h, required 3f800000", got); end
    bus_write(3'd4, 32'd5, st);
    bus_read(3'd3, got, st);
    n_cmp++;
    if (got !== 32'h10) begin n_err++; $display("FAIL lenwr_status: got %h, required 00000010", got); end
    bus_read(3'd4, got, st);
    n_cmp++;
    if (got !== 32'd5) begin n_err++; $display("FAIL len_readback: got %h, required 00000005", got); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, e;
    int st;
    bus_write(3'd3, 32'h1, st);
    bus_write(3'd0, 32'h40000000, st);
    bus_write(3'd1, 32'h40400000, st);
    exp_q.push_back(32'h40C00000);
    bus_write(3'd0, 32'h41200000, st);
    n_cmp++;
    if (st != 2) begin n_err++; $display("FAIL stall_cycles: got %0d, required 2", st); end
    bus_read(3'd2, got, st);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL stall_acc: got %h, required %h", got, e); end
    bus_write(3'd1, 32'h3F800000, st);
    exp_q.push_back(32'h41800000);
    bus_read(3'd2, got, st);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL stall_opa_taken: got %h, required %h", got, e); end
  endtask

  task automatic test_mode();
    logic [31:0] got, e;
    int st;
    bus_write(3'd3, 32'h2, st);
    bus_write(3'd2, 32'h41200000, st);
    do_op(32'h40400000, 32'h40800000, 32'h41400000);
    bus_read(3'd2, got, st);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL mode1_acc: got %h, required %h", got, e); end
    bus_write(3'd3, 32'h0, st);
    do_op(32'h3F800000, 32'h3F800000, 32'h41500000);
    bus_read(3'd2, got, st);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL mode0_resume: got %h, required %h", got, e); end
  endtask

  task automatic test_fp_edges();
    logic [31:0] accv[8], av[8], bv[8], ev[8], fv[8];
    logic [31:0] got, e, ef;
    int st;
    accv = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h7F800000};
    av   = '{32'h7F000000, 32'h7FC00001, 32'h7F800000, 32'h00800000,
             32'hBF800000, 32'h33C00000, 32'hB3C00000, 32'hFF800000};
    bv   = '{32'h7F000000, 32'h3F800000, 32'h00000000, 32'h00800000,
             32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    ev   = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
             32'h00000000, 32'h3F800000, 32'h3F7FFFFE, 32'h7FC00000};
    fv   = '{32'h2, 32'h1, 32'h1, 32'h4, 32'h0, 32'h0, 32'h0, 32'h1};
    for (int i = 0; i < 8; i++) begin
      bus_write(3'd3, 32'h1, st);
      bus_write(3'd2, accv[i], st);
      do_op(av[i], bv[i], ev[i]);
      bus_read(3'd2, got, st);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL fp_edge%0d_acc: got %h, required %h", i, got, e); end
      ef = FLG ? fv[i] : 32'd0;
      bus_read(3'd5, got, st);
      n_cmp++;
      if (got !== ef) begin n_err++; $display("FAIL fp_edge%0d_flags: got %h, required %h", i, got, ef); end
      bus_read(3'd5, got, st);
      n_cmp++;
      if (got !== 32'd0) begin n_err++; $display("FAIL fp_edge%0d_flags_clr: got %h, required 00000000", i, got); end
    end
    bus_write(3'd3, 32'h1, st);
    do_op(32'h3FC00001, 32'h3FC00001, 32'h40100001);
    bus_read(3'd2, got, st);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL mul_truncate: got %h, required %h", got, e); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got, e;
    int st;
    bus_write(3'd3, 32'h2, st);
    bus_write(3'd4, 32'd7, st);
    bus_write(3'd0, 32'h40000000, st);
    bus_write(3'd1, 32'h40000000, st);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_read(3'd2, got, st);
    n_cmp++;
    if (got !== 32'd0 || st != 0) begin
      n_err++; $display("FAIL abort_acc: got %h stalls %0d, required 00000000 stalls 0", got, st);
    end
    bus_read(3'd3, got, st);
    n_cmp++;
    if (got !== 32'd0) begin n_err++; $display("FAIL abort_status: got %h, required 00000000", got); end
    bus_read(3'd4, got, st);
    n_cmp++;
    if (got !== 32'd0) begin n_err++; $display("FAIL abort_len: got %h, required 00000000", got); end
    bus_write(3'd2, 32'h3F800000, st);
    do_op(32'h3F800000, 32'h40000000, 32'h40400000);
    bus_read(3'd2, got, st);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL abort_mode_reset: got %h, required %h", got, e); end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; address = 3'd0; writedata = 32'd0; write = 1'b0; read = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_len_done();
    test_back_to_back();
    test_mode();
    test_fp_edges();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
